// File: rtl/rx_chan_scheduler.sv
// rtl/rx_chan_scheduler.sv - RX packet source scheduler: round-robin/command-priority grant, start/busy handshake, builder timeout
module rx_chan_scheduler #(
  parameter int NUM_CHAN = 1,
  parameter int TIMEOUT  = 1023
) (
  input  logic              rxclk,
  input  logic              reset,
  input  logic [NUM_CHAN:0] chan_ready,
  input  logic              have_space,
  input  logic              cmd_priority,
  input  logic              pkt_done,
  input  logic              clear_status,
  output logic [3:0]        rd_select,
  output logic              start,
  output logic              busy,
  output logic              abort,
  output logic              timeout_err,
  output logic [1:0]        state_dbg
);
  localparam int          NSRC       = NUM_CHAN + 1;
  localparam logic [3:0]  CMD_IDX    = 4'(NUM_CHAN);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2} state_t;

  state_t            state;
  logic [3:0]        last;
  logic [15:0]       timer;
  logic [2*NSRC-1:0] doubled;
  logic [NSRC-1:0]   rotated;
  logic [3:0]        rot_base;
  logic [3:0]        winner;
  logic              found;

  // Rotate the ready vector so bit 0 is the source right after the last grant,
  // then the lowest set bit of the rotated vector is the round-robin winner.
  always_comb begin
    doubled  = {chan_ready, chan_ready};
    rot_base = (last == CMD_IDX) ? 4'd0 : last + 4'd1;
    rotated  = NSRC'(doubled >> rot_base);
    winner   = last;
    found    = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (!found && rotated[i]) begin
        found = 1'b1;
        if (i + int'(rot_base) >= NSRC)
          winner = rot_base + 4'(i) - 4'(NSRC);
        else
          winner = rot_base + 4'(i);
      end
    end
    if (cmd_priority && chan_ready[NUM_CHAN])
      winner = CMD_IDX;
  end

  always_ff @(posedge rxclk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= CMD_IDX;
      timer       <= '0;
      rd_select   <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      abort       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      start <= 1'b0;
      abort <= 1'b0;
      if (clear_status)
        timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (have_space && (|chan_ready)) begin
            rd_select <= winner;
            last      <= winner;
            start     <= 1'b1;
            busy      <= 1'b1;
            timer     <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (timer != 16'hFFFF)
            timer <= timer + 16'd1;
          // A completion arriving on the timeout cycle is honoured, not aborted.
          if (pkt_done) begin
            busy  <= 1'b0;
            state <= GAP;
          end else if (timer == TIMER_LAST) begin
            abort       <= 1'b1;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;

endmodule
